mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Initiator for the combinational 4-lane int8 MAC: streams packed 32-bit operand pairs into the
//  MAC's a/b/p inputs and closes the accumulation loop via its c output (next p = previous c).
//  Computes an LEN-word dot product (4*LEN byte products) mod 256 and returns it on a
//  valid/ready result port. Sits between the operand-fetch path and the MAC.
// PARAMETERS
//  LEN_W   8   width of the word-count input len; max job = 2^LEN_W-1 word pairs
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      job start pulse; sampled only in IDLE
//  len        in   LEN_W  number of 32-bit word pairs in the job; sampled with start
//  init       in   8      initial accumulator value; sampled with start
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      operand pair accepted when in_valid & in_ready
//  in_a       in   32     four packed uint8 lanes, lane0 = [7:0]
//  in_b       in   32     four packed uint8 lanes, lane0 = [7:0]
//  mac_a      out  32     to MAC a
//  mac_b      out  32     to MAC b
//  mac_p      out  8      to MAC p (current accumulator)
//  mac_c      in   8      from MAC c (combinational, same cycle)
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumer ready
//  out_data   out  8      result = accumulator
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; acc, cnt, op_a, op_b, op_vld = 0; in_ready=0,
//   out_valid=0, out_data=0, mac_a=mac_b=0, mac_p=0, busy=0. Takes effect mid-job; the job is
//   discarded and no result is produced.
//  Registers: acc[7:0], cnt[LEN_W-1:0], op_a/op_b[31:0], op_vld.
//   mac_a=op_vld?op_a:0, mac_b=op_vld?op_b:0, mac_p=acc, out_data=acc (all from registers).
//  FSM states:
//   IDLE : in_ready=0. start=1 -> acc<=init, cnt<=len; next RUN if len!=0, else DONE.
//          in_valid in IDLE is ignored (no handshake).
//   RUN  : in_ready=1. On handshake: op_a<=in_a, op_b<=in_b, op_vld<=1, cnt<=cnt-1;
//          if cnt==1 -> DRAIN. No handshake -> op_vld<=0, stay.
//   DRAIN: in_ready=0, op_vld<=0 -> DONE (last beat retires this cycle).
//   DONE : out_valid=1; out_data/out_valid held stable while out_ready=0;
//          out_ready=1 -> IDLE.
//  Every state: op_vld=1 -> acc<=mac_c (one word accumulated per cycle; back-to-back beats
//   give full throughput). op_vld=0 -> acc holds.
//  Latency: last operand handshake at edge E -> acc final at E+1 -> out_valid high from the
//   cycle after E+1 (2 cycles). For len=0, out_valid is high the cycle after start, with
//   out_data=init.
//  start outside IDLE is ignored; len/init are not re-sampled mid-job.
//  Arithmetic: modulo 256, wrap performed by the MAC; no saturation and no overflow flag.
//  Gaps in in_valid insert op_vld=0 bubbles; the result is unaffected.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; state IDLE; busy=0.
//  2 len=1, init=0x05, a=0x01020304, b=0x01010101 -> out_valid 2 cycles after the handshake,
//    out_data=0x0F.
//  3 len=3 back-to-back, init=0, a=0x02020202, b=0x03030303 -> in_ready high 3 cycles,
//    out_data=0x48.
//  4 Wrap: len=1, init=0xFE, a=b=0x11111111 -> out_data=0x82.
//  5 len=0, init=0xA5 -> in_ready never high, out_valid next cycle, out_data=0xA5; hold
//    out_ready=0 for 3 cycles (outputs stable, start ignored), then out_ready=1 -> IDLE.
//  6 len=4 with in_valid gaps, then rst_n=0 after 2 beats -> no out_valid; a new job
//    (len=1, init=0x05, operands as in test 2) gives 0x0F.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Bundles the job, operand, MAC-loop and result signals of mac_seq_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       init;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic [7:0]       mac_p;
  logic [7:0]       mac_c;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;

  modport slave (
    input  start, len, init, in_valid, in_a, in_b, mac_c, out_ready,
    output in_ready, mac_a, mac_b, mac_p, out_valid, out_data, busy
  );

  modport master (
    output start, len, init, in_valid, in_a, in_b, mac_c, out_ready,
    input  in_ready, mac_a, mac_b, mac_p, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for an external combinational 4-lane int8 MAC: streams operand words into it,
// feeds the MAC result back as the next accumulator and returns the mod-256 dot product.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);

  state_t           state_q;
  logic [7:0]       acc_q;
  logic [7:0]       acc_d;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic             op_vld_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             hs_s;

  assign hs_s = in_ready_q & bus.in_valid;

  // The MAC output is only meaningful while a registered beat is presented to it.
  always_comb begin
    acc_d = acc_q;
    if (op_vld_q) begin
      acc_d = bus.mac_c;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 8'd0;
      cnt_q       <= CNT_ZERO;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      op_vld_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          op_vld_q <= 1'b0;
          if (bus.start) begin
            acc_q  <= bus.init;
            cnt_q  <= bus.len;
            busy_q <= 1'b1;
            if (bus.len != CNT_ZERO) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs_s) begin
            op_a_q   <= bus.in_a;
            op_b_q   <= bus.in_b;
            op_vld_q <= 1'b1;
            cnt_q    <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end else begin
            op_vld_q <= 1'b0;
          end
        end
        // The last beat retires into acc on this edge; the result is final in DONE.
        DRAIN: begin
          op_vld_q    <= 1'b0;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          op_vld_q <= 1'b0;
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          op_vld_q    <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = acc_q;
  assign bus.mac_p     = acc_q;
  assign bus.mac_a     = op_vld_q ? op_a_q : 32'd0;
  assign bus.mac_b     = op_vld_q ? op_b_q : 32'd0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized and directed bench for mac_seq_ctrl; includes a behavioural MAC and a
// dot-product reference model computed directly from the job operands.
module tb_mac_seq_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  logic [31:0] a_arr [256];
  logic [31:0] b_arr [256];

  mac_seq_ctrl_if #(.LEN_W(8)) bus ();

  mac_seq_ctrl #(.LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural combinational MAC: p plus four lane products, wrapped to 8 bits.
  assign bus.mac_c = 8'(32'(bus.mac_p)
                     + 32'(bus.mac_a[7:0])   * 32'(bus.mac_b[7:0])
                     + 32'(bus.mac_a[15:8])  * 32'(bus.mac_b[15:8])
                     + 32'(bus.mac_a[23:16]) * 32'(bus.mac_b[23:16])
                     + 32'(bus.mac_a[31:24]) * 32'(bus.mac_b[31:24]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_dot(input int n, input logic [7:0] ini);
    int s;
    s = int'(ini);
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 4; l++) begin
        s += int'(a_arr[i][8*l +: 8]) * int'(b_arr[i][8*l +: 8]);
      end
    end
    return 8'(s % 256);
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
    check_eq("rst_mac_a",     bus.mac_a,          32'd0);
    check_eq("rst_mac_b",     bus.mac_b,          32'd0);
    check_eq("rst_mac_p",     32'(bus.mac_p),     32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
  endtask

  task automatic run_job(input int n, input logic [7:0] ini, input int gap,
                         input int hold, input bit chk_rdy);
    int         idx;
    int         guard;
    int         rdy_cnt;
    bit         hs;
    logic [7:0] exp_v;
    logic [7:0] held;
    exp_v = ref_dot(n, ini);
    @(negedge clk);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    bus.init  = ini;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
    bus.init  = 8'($urandom);
    check_eq("busy_job", 32'(bus.busy), 32'd1);
    if (n == 0) begin
      check_eq("len0_in_ready",  32'(bus.in_ready),  32'd0);
      check_eq("len0_out_valid", 32'(bus.out_valid), 32'd1);
    end else begin
      idx     = 0;
      guard   = 0;
      rdy_cnt = 0;
      while (idx < n && guard < 2000) begin
        bus.in_valid = ($urandom_range(0, 99) >= gap);
        bus.in_a     = a_arr[idx];
        bus.in_b     = b_arr[idx];
        if (bus.in_ready) rdy_cnt++;
        hs = bus.in_valid && bus.in_ready;
        @(negedge clk);
        guard++;
        if (hs) idx++;
      end
      bus.in_valid = 1'b0;
      check_eq("beats_accepted", 32'(idx), 32'(n));
      check_eq("drain_in_ready",  32'(bus.in_ready),  32'd0);
      check_eq("drain_out_valid", 32'(bus.out_valid), 32'd0);
      if (chk_rdy) check_eq("ready_cycles", 32'(rdy_cnt), 32'(n));
      @(negedge clk);
      check_eq("latency_out_valid", 32'(bus.out_valid), 32'd1);
    end
    check_eq("result", 32'(bus.out_data), 32'(exp_v));
    held = exp_v;
    for (int i = 0; i < hold; i++) begin
      bus.start = 1'b1;
      @(negedge clk);
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_out_data",  32'(bus.out_data),  32'(held));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("pop_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("pop_busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin
    int guard;
    int beats;
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.init      = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    a_arr[0] = 32'h01020304; b_arr[0] = 32'h01010101;
    run_job(1, 8'h05, 0, 0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      a_arr[i] = 32'h02020202; b_arr[i] = 32'h03030303;
    end
    run_job(3, 8'h00, 0, 1, 1'b1);

    a_arr[0] = 32'h11111111; b_arr[0] = 32'h11111111;
    run_job(1, 8'hFE, 0, 0, 1'b1);

    run_job(0, 8'hA5, 0, 3, 1'b0);

    // Mid-job reset: accept two of four beats, then drop rst_n partway through a cycle.
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = $urandom; b_arr[i] = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd4; bus.init = 8'h33;
    @(negedge clk);
    bus.start = 1'b0;
    beats = 0; guard = 0;
    while (beats < 2 && guard < 200) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_a = a_arr[beats]; bus.in_b = b_arr[beats];
      if (bus.in_valid && bus.in_ready) beats++;
      @(negedge clk);
      guard++;
    end
    check_eq("midjob_beats", 32'(beats), 32'd2);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    a_arr[0] = 32'h01020304; b_arr[0] = 32'h01010101;
    run_job(1, 8'h05, 0, 0, 1'b1);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        a_arr[i] = $urandom; b_arr[i] = $urandom;
      end
      run_job(n, 8'($urandom), $urandom_range(0, 60), $urandom_range(0, 3), 1'b0);
    end

    a_arr[0] = 32'hFFFFFFFF; b_arr[0] = 32'hFFFFFFFF;
    a_arr[1] = 32'hFFFFFFFF; b_arr[1] = 32'hFFFFFFFF;
    run_job(2, 8'hFF, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
